// File: rtl/alu_pkg.sv
// Shared datapath constants: operand width, register addressing, flag bit
// positions and the ALU operation select encoding.
package alu_pkg;

    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ZERO_REG = 31;

    // Bit positions inside the 4-bit status word {N,V,Z,C}
    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_V = 2;
    localparam int unsigned FLAG_N = 3;

    typedef logic [3:0] flags_t;

    typedef enum logic [3:0] {
        ALU_SEL_ADD = 4'h0,
        ALU_SEL_SUB = 4'h1,
        ALU_SEL_ADC = 4'h2,
        ALU_SEL_SBC = 4'h3,
        ALU_SEL_AND = 4'h4,
        ALU_SEL_ORR = 4'h5,
        ALU_SEL_EOR = 4'h6,
        ALU_SEL_LSL = 4'h7,
        ALU_SEL_LSR = 4'h8,
        ALU_SEL_ASR = 4'h9,
        ALU_SEL_MOV = 4'hA
    } alu_sel_e;

endpackage

// File: rtl/regfile_32x64_flag_reg.sv
// flag_reg: load-enabled status register with asynchronous active-low clear.
module flag_reg #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] state_q;
    logic [W-1:0] state_d;

    // Load new status only when enabled, otherwise hold
    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = d;
        end
    end

    // State register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/regfile_32x64.sv
// regfile_32x64: operand register file (2 combinational reads, 1 synchronous
// write) plus the condition-flag register. Index ZERO_REG always reads zero.
// Optional macro REGFILE_BYPASS_EN selects write-first forwarding on the read
// ports; without it the read ports are read-first. Flags are never forwarded.
module regfile_32x64 #(
    parameter int unsigned DATA_W   = alu_pkg::DATA_W,
    parameter int unsigned ADDR_W   = alu_pkg::ADDR_W,
    parameter int unsigned ZERO_REG = alu_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flag_we,
    input  logic [3:0]        flag_in,
    output logic [3:0]        flags,
    output logic              carry_q
);

    import alu_pkg::*;

    localparam int unsigned       NUM_REGS  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];
    logic              wr_ok;
    flags_t            flags_q;

    // Writes to the zero register are dropped; an unknown wr_en never commits
    assign wr_ok = wr_en && (wr_addr != ZERO_ADDR);

    // Next-state of the storage array
    always_comb begin
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Storage array, cleared asynchronously; reset wins over a coincident write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit_a;
    logic hit_b;
    assign hit_a = wr_ok && (wr_addr == rd_addr_a);
    assign hit_b = wr_ok && (wr_addr == rd_addr_b);

    // Read muxes with write-first forwarding
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (hit_a) begin
            rd_data_a = wr_data;
        end else if (rd_addr_a != ZERO_ADDR) begin
            rd_data_a = mem_q[rd_addr_a];
        end
        if (hit_b) begin
            rd_data_b = wr_data;
        end else if (rd_addr_b != ZERO_ADDR) begin
            rd_data_b = mem_q[rd_addr_b];
        end
    end
`else
    // Read muxes, read-first: stored contents only
    always_comb begin
        rd_data_a = '0;
        rd_data_b = '0;
        if (rd_addr_a != ZERO_ADDR) begin
            rd_data_a = mem_q[rd_addr_a];
        end
        if (rd_addr_b != ZERO_ADDR) begin
            rd_data_b = mem_q[rd_addr_b];
        end
    end
`endif

    flag_reg #(
        .W (4)
    ) u_flag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (flag_we),
        .d     (flag_in),
        .q     (flags_q)
    );

    assign flags   = flags_q;
    assign carry_q = flags_q[FLAG_C];

endmodule

// File: tb/tb_regfile_32x64.sv
// Directed testbench for regfile_32x64 with hand-computed expectations.
// Expected forwarding behaviour follows REGFILE_BYPASS_EN as built.
module tb_regfile_32x64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        flag_we;
    logic [3:0]  flag_in;
    logic [3:0]  flags;
    logic        carry_q;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
    localparam logic [63:0] HAZARD_EXP = 64'h2;
`else
    localparam logic [63:0] HAZARD_EXP = 64'h1;
`endif

    regfile_32x64 #(
        .DATA_W   (64),
        .ADDR_W   (5),
        .ZERO_REG (31)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .flag_we   (flag_we),
        .flag_in   (flag_in),
        .flags     (flags),
        .carry_q   (carry_q)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            assert (!$isunknown({wr_en, flag_we}))
                else $error("wr_en/flag_we unknown while out of reset");
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [63:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic read(input logic [4:0] a, input logic [4:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        flag_we   = 1'b0;
        flag_in   = '0;
        #12;
        rst_n = 1'b1;

        // Preload contents so the reset sweep clears something real
        for (int unsigned i = 0; i < 31; i++) begin
            write(5'(i), {32'hA5A5_0000, 32'(i + 1)});
        end
        flag_we = 1'b1;
        flag_in = 4'hF;
        step();
        flag_we = 1'b0;
        read(5'd4, 5'd30);
        check("preload_r4", rd_data_a, 64'hA5A5_0000_0000_0005);
        check("preload_flags", {60'd0, flags}, 64'hF);

        // 1. Asynchronous reset mid-cycle, observed before any clock edge
        rst_n = 1'b0;
        #1;
        check("rst_flags", {60'd0, flags}, 64'h0);
        check("rst_carry", {63'd0, carry_q}, 64'h0);
        check("rst_r4_now", rd_data_a, 64'h0);
        for (int unsigned i = 0; i < 32; i++) begin
            read(5'(i), 5'(31 - i));
            check($sformatf("rst_a_r%0d", i), rd_data_a, 64'h0);
            check($sformatf("rst_b_r%0d", 31 - i), rd_data_b, 64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 2. Write then read
        write(5'd5, 64'hDEAD_BEEF_0123_4567);
        read(5'd5, 5'd0);
        check("wr_rd_r5", rd_data_a, 64'hDEAD_BEEF_0123_4567);
        check("untouched_r0", rd_data_b, 64'h0);
        read(5'd5, 5'd5);
        check("same_addr_a", rd_data_a, 64'hDEAD_BEEF_0123_4567);
        check("same_addr_b", rd_data_b, 64'hDEAD_BEEF_0123_4567);

        // 3. Zero register ignores writes, neighbour unaffected
        write(5'd30, 64'h3030_3030_CAFE_F00D);
        write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        read(5'd31, 5'd31);
        check("xzr_a", rd_data_a, 64'h0);
        check("xzr_b", rd_data_b, 64'h0);
        read(5'd30, 5'd31);
        check("r30_kept", rd_data_a, 64'h3030_3030_CAFE_F00D);

        // 4. Flags, with a simultaneous register write
        flag_we = 1'b1;
        flag_in = 4'b1001;
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 64'h9999;
        step();
        wr_en   = 1'b0;
        flag_we = 1'b0;
        flag_in = 4'b0110;
        read(5'd9, 5'd0);
        check("flags_load", {60'd0, flags}, 64'h9);
        check("carry_set", {63'd0, carry_q}, 64'h1);
        check("wr_with_flags", rd_data_a, 64'h9999);
        step();
        check("flags_hold", {60'd0, flags}, 64'h9);
        flag_we = 1'b1;
        #1;
        check("flags_no_bypass", {60'd0, flags}, 64'h9);
        step();
        flag_we = 1'b0;
        check("flags_0110", {60'd0, flags}, 64'h6);
        check("carry_clr", {63'd0, carry_q}, 64'h0);

        // 5. Same-cycle read/write hazard
        write(5'd7, 64'h1);
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_data = 64'h2;
        read(5'd5, 5'd7);
        check("hazard_b", rd_data_b, HAZARD_EXP);
        check("hazard_other_a", rd_data_a, 64'hDEAD_BEEF_0123_4567);
        step();
        wr_en = 1'b0;
        #1;
        check("hazard_after", rd_data_b, 64'h2);
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        read(5'd31, 5'd7);
        check("xzr_no_fwd", rd_data_a, 64'h0);
        step();
        wr_en = 1'b0;

        // 6. Reset during a write discards it
        write(5'd3, 64'h3333);
        read(5'd3, 5'd5);
        check("r3_before", rd_data_a, 64'h3333);
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 64'hBAD0_BAD0;
        #2;
        rst_n = 1'b0;
        step();
        wr_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        read(5'd3, 5'd5);
        check("rst_wr_r3", rd_data_a, 64'h0);
        check("rst_wr_r5", rd_data_b, 64'h0);
        write(5'd3, 64'h0ABC);
        read(5'd3, 5'd3);
        check("post_rst_wr", rd_data_a, 64'h0ABC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
